// File: rtl/shot_sequencer.sv
// shot_sequencer: run-level controller that drives accumulator clear, BRAM rewind and shot triggers.
// Define SHOT_TIMEOUT_EN to add the per-shot timeout input and the sticky timeout flag.
module shot_sequencer #(
   parameter int NPROC  = 8,
   parameter int CNTW   = 32,
   parameter int DELAYW = 32
`ifdef SHOT_TIMEOUT_EN
   ,
   parameter int TMOW   = 24
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stb_start,
   input  logic              stb_abort,
   input  logic [CNTW-1:0]   nshot,
   input  logic [DELAYW-1:0] delayaftertrig,
   input  logic [NPROC-1:0]  proc_mask,
   input  logic [NPROC-1:0]  procdone,
`ifdef SHOT_TIMEOUT_EN
   input  logic [TMOW-1:0]   shot_timeout,
`endif
   output logic              resetacc,
   output logic              stb_reset_bram_read,
   output logic              shot_trig,
   output logic [CNTW-1:0]   shotcnt,
   output logic              lastshotdone,
   output logic              busy,
   output logic              timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_START,
      S_RUN,
      S_DELAY,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CNTW-1:0]     nshot_q;
   logic [DELAYW-1:0]   delay_q;
   logic [NPROC-1:0]    mask_q;
   logic [NPROC-1:0]    done_q;
   logic [CNTW-1:0]     shotcnt_q;
   logic                last_q;
   logic [DELAYW-1:0]   dly_cnt_q;
   logic                cmp_q;
   logic                start_acc;
   logic                all_done;
   logic                last_shot;
   logic                tmo_hit;
   logic                kill;

   assign start_acc = stb_start && ((state_q == S_IDLE) || ((state_q == S_DONE) && !stb_abort));
   assign all_done  = ((done_q | (procdone & mask_q)) == mask_q);
   assign last_shot = (shotcnt_q == nshot_q);
   assign kill      = (state_q != S_IDLE) && (stb_abort || tmo_hit);

   // cmp_q marks the cycle after completion, when shotcnt already shows the finished shot
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_acc) state_d = S_ARM;
         S_ARM:   state_d = (nshot_q == '0) ? S_DONE : S_START;
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (cmp_q) begin
               if (delay_q != '0) state_d = S_DELAY;
               else               state_d = last_shot ? S_DONE : S_START;
            end
         end
         S_DELAY: if (dly_cnt_q == DELAYW'(1)) state_d = last_shot ? S_DONE : S_START;
         S_DONE:  state_d = start_acc ? S_ARM : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (kill) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         nshot_q   <= '0;
         delay_q   <= '0;
         mask_q    <= '0;
         done_q    <= '0;
         shotcnt_q <= '0;
         last_q    <= 1'b0;
         dly_cnt_q <= '0;
         cmp_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            nshot_q   <= nshot;
            delay_q   <= delayaftertrig;
            mask_q    <= proc_mask;
            shotcnt_q <= '0;
            last_q    <= 1'b0;
         end
         if (state_q == S_START) begin
            done_q <= '0;
            cmp_q  <= 1'b0;
         end else if ((state_q == S_RUN) && !cmp_q) begin
            done_q <= done_q | (procdone & mask_q);
            // an abort or timeout in the completing cycle wins: the shot is not counted
            if (all_done && !kill) begin
               cmp_q     <= 1'b1;
               shotcnt_q <= shotcnt_q + CNTW'(1);
            end
         end
         if ((state_q == S_RUN) && (state_d == S_DELAY)) dly_cnt_q <= delay_q;
         else if (state_q == S_DELAY)                   dly_cnt_q <= dly_cnt_q - DELAYW'(1);
         if (state_d == S_DONE) last_q <= 1'b1;
      end
   end

`ifdef SHOT_TIMEOUT_EN
   logic [TMOW-1:0] tmo_cnt_q;
   logic            tmo_q;

   assign tmo_hit = (state_q == S_RUN) && !cmp_q && (shot_timeout != '0) &&
                    ((tmo_cnt_q + TMOW'(1)) == shot_timeout);

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         if (start_acc)    tmo_q <= 1'b0;
         else if (tmo_hit) tmo_q <= 1'b1;
         if (state_q == S_START)                tmo_cnt_q <= '0;
         else if ((state_q == S_RUN) && !cmp_q) tmo_cnt_q <= tmo_cnt_q + TMOW'(1);
      end
   end

   assign timeout = tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign resetacc            = (state_q == S_ARM);
   assign stb_reset_bram_read = (state_q == S_START);
   assign shot_trig           = (state_q == S_START);
   assign shotcnt             = shotcnt_q;
   assign lastshotdone        = last_q;
   assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: randomized runs checked against a per-run event timeline model.
`timescale 1ns/1ps
module tb_shot_sequencer;

   localparam int NPROC  = 8;
   localparam int CNTW   = 32;
   localparam int DELAYW = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              stb_start;
   logic              stb_abort;
   logic [CNTW-1:0]   nshot;
   logic [DELAYW-1:0] delayaftertrig;
   logic [NPROC-1:0]  proc_mask;
   logic [NPROC-1:0]  procdone;
   logic              resetacc;
   logic              stb_reset_bram_read;
   logic              shot_trig;
   logic [CNTW-1:0]   shotcnt;
   logic              lastshotdone;
   logic              busy;
   logic              timeout;
`ifdef SHOT_TIMEOUT_EN
   logic [23:0]       shot_timeout;
`endif

   int ncmp = 0;
   int nmis = 0;
   int off_tab[8][8];

   always #5 clk = ~clk;

   shot_sequencer #(.NPROC(NPROC), .CNTW(CNTW), .DELAYW(DELAYW)) dut (
      .clk(clk),
      .reset(reset),
      .stb_start(stb_start),
      .stb_abort(stb_abort),
      .nshot(nshot),
      .delayaftertrig(delayaftertrig),
      .proc_mask(proc_mask),
      .procdone(procdone),
`ifdef SHOT_TIMEOUT_EN
      .shot_timeout(shot_timeout),
`endif
      .resetacc(resetacc),
      .stb_reset_bram_read(stb_reset_bram_read),
      .shot_trig(shot_trig),
      .shotcnt(shotcnt),
      .lastshotdone(lastshotdone),
      .busy(busy),
      .timeout(timeout)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic fill_off(input int v);
      for (int i = 0; i < 8; i++)
         for (int b = 0; b < 8; b++) off_tab[i][b] = v;
   endtask

   // One run: cycle 0 issues stb_start. Shot i triggers at trig[i]; masked processor b
   // pulses procdone at trig[i]+off_tab[i][b]. The shot completes at rr[i] (latest masked
   // pulse, or one RUN cycle if nothing is masked), shotcnt counts it from rr[i]+1, and the
   // next trigger (or DONE) comes delay+2 cycles after completion.
   // kill_c: -1 none, -2 random cycle inside the run, else that cycle; kill_rst picks reset
   // instead of stb_abort.
   task automatic do_run(input int ns, input int dly, input logic [7:0] msk, input bit rnd_off,
                         input int kill_in, input bit kill_rst, input bit ign_start);
      int trig[8];
      int rr[8];
      int done_c, last_c, ign_c, kill_c, ntrig, ntrig_exp, lim, cnt_exp, m;
      bit dead, trig_exp;
      logic [7:0] pd;
      if (rnd_off)
         for (int i = 0; i < 8; i++)
            for (int b = 0; b < 8; b++) off_tab[i][b] = $urandom_range(1, 6);
      for (int i = 0; i < ns; i++) begin
         trig[i] = (i == 0) ? 2 : rr[i-1] + dly + 2;
         m = 1;
         for (int b = 0; b < 8; b++)
            if (msk[b] && off_tab[i][b] > m) m = off_tab[i][b];
         rr[i] = trig[i] + m;
      end
      done_c = (ns == 0) ? 2 : rr[ns-1] + dly + 2;
      kill_c = (kill_in == -2) ? $urandom_range(1, done_c - 1) : kill_in;
      last_c = (kill_c > 0) ? kill_c + 2 : done_c + 1;
      ign_c  = (ign_start && ns > 0 && (kill_c <= 0 || kill_c > trig[0] + 1)) ? trig[0] + 1 : -1;
      ntrig  = 0;
      for (int k = 0; k <= last_c; k++) begin
         @(negedge clk);
         if (k > 0) begin
            dead = (kill_c > 0) && (k > kill_c);
            cnt_exp = 0;
            for (int i = 0; i < ns; i++)
               if (rr[i] + 1 <= k && (kill_c <= 0 || rr[i] + 1 <= kill_c)) cnt_exp++;
            if (dead && kill_rst) cnt_exp = 0;
            trig_exp = 1'b0;
            for (int i = 0; i < ns; i++)
               if (trig[i] == k) trig_exp = !dead;
            if (shot_trig === 1'b1) ntrig++;
            check_val($sformatf("resetacc@%0d", k), resetacc, (k == 1));
            check_val($sformatf("shot_trig@%0d", k), shot_trig, trig_exp);
            check_val($sformatf("rewind@%0d", k), stb_reset_bram_read, trig_exp);
            check_val($sformatf("shotcnt@%0d", k), shotcnt, cnt_exp);
            check_val($sformatf("lastshotdone@%0d", k), lastshotdone, (!dead && k >= done_c));
            check_val($sformatf("busy@%0d", k), busy, (!dead && k <= done_c));
            check_val($sformatf("timeout@%0d", k), timeout, 0);
         end
         stb_start = (k == 0) || (k == ign_c);
         stb_abort = (k == kill_c) && !kill_rst;
         reset     = (k == kill_c) && kill_rst;
         if (k == 0) begin
            nshot          = ns;
            delayaftertrig = dly;
            proc_mask      = msk;
         end else begin
            nshot          = $urandom;
            delayaftertrig = $urandom;
            proc_mask      = 8'($urandom);
         end
         pd = 8'($urandom) & ~msk;
         for (int i = 0; i < ns; i++)
            for (int b = 0; b < 8; b++)
               if (msk[b] && k == trig[i] + off_tab[i][b]) pd[b] = 1'b1;
         procdone = pd;
      end
      lim = (kill_c > 0) ? kill_c : last_c;
      ntrig_exp = 0;
      for (int i = 0; i < ns; i++)
         if (trig[i] <= lim) ntrig_exp++;
      check_val("ntrig", ntrig, ntrig_exp);
   endtask

   initial begin
      reset = 1'b1;
      stb_start = 1'b0;
      stb_abort = 1'b0;
      nshot = '0;
      delayaftertrig = '0;
      proc_mask = '0;
      procdone = '0;
`ifdef SHOT_TIMEOUT_EN
      shot_timeout = '0;
`endif
      repeat (3) @(negedge clk);
      check_val("rst_resetacc", resetacc, 0);
      check_val("rst_shot_trig", shot_trig, 0);
      check_val("rst_rewind", stb_reset_bram_read, 0);
      check_val("rst_shotcnt", shotcnt, 0);
      check_val("rst_lastshotdone", lastshotdone, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_timeout", timeout, 0);
      reset = 1'b0;
      @(negedge clk);

      // three shots, 10-cycle hold-off, all four processors done 5 cycles after trigger
      fill_off(5);
      do_run(3, 10, 8'h0F, 1'b0, -1, 1'b0, 1'b0);
      // empty run
      do_run(0, 4, 8'hFF, 1'b1, -1, 1'b0, 1'b0);
      // bits 0 and 2 on separate cycles, bit 1 is noise
      fill_off(2);
      off_tab[0][2] = 4;
      do_run(1, 0, 8'h05, 1'b0, -1, 1'b0, 1'b0);
      // abort right after the second shot is counted, then restart from zero
      fill_off(2);
      do_run(5, 3, 8'h03, 1'b0, 12, 1'b0, 1'b0);
      do_run(2, 1, 8'h03, 1'b1, -1, 1'b0, 1'b0);
      // stb_start while running is ignored
      do_run(2, 2, 8'hFF, 1'b1, -1, 1'b0, 1'b1);
      // reset while in the hold-off
      fill_off(3);
      do_run(2, 10, 8'hFF, 1'b0, 9, 1'b1, 1'b0);
      // nothing masked: each shot takes one RUN cycle
      do_run(3, 0, 8'h00, 1'b1, -1, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         int ns, dly, sel, kr;
         logic [7:0] msk;
         ns  = $urandom_range(0, 5);
         dly = $urandom_range(0, 6);
         sel = $urandom_range(0, 3);
         msk = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
         kr  = $urandom_range(0, 9);
         do_run(ns, dly, msk, 1'b1, (kr < 3) ? -2 : -1, (kr == 0), $urandom_range(0, 1) == 1);
      end

`ifdef SHOT_TIMEOUT_EN
      shot_timeout = 24'd100;
      @(negedge clk);
      stb_start = 1'b1;
      nshot = 1;
      delayaftertrig = 0;
      proc_mask = 8'h01;
      procdone = '0;
      @(negedge clk);
      stb_start = 1'b0;
      repeat (101) @(negedge clk);
      check_val("tmo_before_timeout", timeout, 0);
      check_val("tmo_before_busy", busy, 1);
      @(negedge clk);
      check_val("tmo_timeout", timeout, 1);
      check_val("tmo_busy", busy, 0);
      check_val("tmo_shotcnt", shotcnt, 0);
      check_val("tmo_lastshotdone", lastshotdone, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
      $finish;
   end

endmodule
